// File: rtl/store_buffer_pkg.sv
// Shared types and mask encodings for the posted-write store buffer.
package store_buffer_pkg;

  localparam int unsigned SB_AW = 32;

  localparam logic [2:0] MASK_B  = 3'b000;
  localparam logic [2:0] MASK_H  = 3'b001;
  localparam logic [2:0] MASK_W  = 3'b010;
  localparam logic [2:0] MASK_BU = 3'b100;
  localparam logic [2:0] MASK_HU = 3'b101;

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [31:0]      data;
    logic [2:0]       mask;
  } sb_entry_t;

endpackage

// File: rtl/sb_fifo.sv
// Store-buffer storage: circular entry array, pointers, occupancy and a
// per-entry word-address match vector against the current load address.
module sb_fifo
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = SB_AW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [AW-1:0]    wr_addr,
  input  logic [31:0]      wr_data,
  input  logic [2:0]       wr_mask,
  input  logic [AW-3:0]    cmp_word,
  output logic [AW-1:0]    head_addr,
  output logic [31:0]      head_data,
  output logic [2:0]       head_mask,
  output logic             full,
  output logic             empty,
  output logic [DEPTH-1:0] match
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  sb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;

  // Payload carries no reset; valid bits alone decide what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      entries[tail] <= '{addr: SB_AW'(wr_addr), data: wr_data, mask: wr_mask};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + PW'(1);
      end
      if (push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign head_addr = AW'(entries[head].addr);
  assign head_data = entries[head].data;
  assign head_mask = entries[head].mask;

  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      match[i] = valid[i] && (entries[i].addr[AW-1:2] == cmp_word);
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the load/store unit and word-addressed data
// memory: loads bypass, stores drain oldest-first when the port is free.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  input  logic [2:0]    cpu_mask,
  input  logic          cpu_wr_en,
  input  logic          cpu_rd_en,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_stall,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [2:0]    mem_mask,
  output logic          mem_wr_en,
  output logic          mem_rd_en,
  input  logic [31:0]   mem_rdata,
  output logic          empty
);

  logic             full;
  logic [DEPTH-1:0] match;
  logic [AW-1:0]    head_addr;
  logic [31:0]      head_data;
  logic [2:0]       head_mask;
  logic             hit;
  logic             load_go;
  logic             drain;
  logic             push;

  sb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (drain),
    .wr_addr   (cpu_addr),
    .wr_data   (cpu_wdata),
    .wr_mask   (cpu_mask),
    .cmp_word  (cpu_addr[AW-1:2]),
    .head_addr (head_addr),
    .head_data (head_data),
    .head_mask (head_mask),
    .full      (full),
    .empty     (empty),
    .match     (match)
  );

  // Everything is gated by reset so a reset cycle cannot leak a buffered
  // store to memory before the synchronous clear takes effect.
  assign hit       = cpu_rd_en & (|match);
  assign load_go   = ~reset & cpu_rd_en & ~hit;
  assign drain     = ~reset & ~load_go & ~empty;
  assign push      = ~reset & cpu_wr_en & ~full;
  assign cpu_stall = ~reset & ((cpu_wr_en & full) | hit);

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_mask  = '0;
    mem_wr_en = 1'b0;
    mem_rd_en = 1'b0;
    cpu_rdata = '0;
    if (load_go) begin
      mem_rd_en = 1'b1;
      mem_addr  = cpu_addr;
      mem_mask  = cpu_mask;
      cpu_rdata = mem_rdata;
    end else if (drain) begin
      mem_wr_en = 1'b1;
      mem_addr  = head_addr;
      mem_wdata = head_data;
      mem_mask  = head_mask;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: behavioural data memory, drain
// scoreboard, load-vector table and hand-written multi-cycle sequences.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;

  logic          clk;
  logic          reset;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [2:0]    cpu_mask;
  logic          cpu_wr_en;
  logic          cpu_rd_en;
  logic [31:0]   cpu_rdata;
  logic          cpu_stall;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [2:0]    mem_mask;
  logic          mem_wr_en;
  logic          mem_rd_en;
  logic [31:0]   mem_rdata;
  logic          empty;

  store_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_mask  (cpu_mask),
    .cpu_wr_en (cpu_wr_en),
    .cpu_rd_en (cpu_rd_en),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_mask  (mem_mask),
    .mem_wr_en (mem_wr_en),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural data memory: sub-word merge on negedge write, extended read.
  logic [31:0] mem [256];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] off,
                                        input logic [31:0] d, input logic [2:0] m);
    logic [31:0] r;
    r = old;
    if (m == MASK_W) r = d;
    else if (m == MASK_H) begin
      if (off[1]) r[31:16] = d[15:0];
      else        r[15:0]  = d[15:0];
    end else if (m == MASK_B) begin
      case (off)
        2'd0: r[7:0]   = d[7:0];
        2'd1: r[15:8]  = d[7:0];
        2'd2: r[23:16] = d[7:0];
        default: r[31:24] = d[7:0];
      endcase
    end
    return r;
  endfunction

  function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [1:0] off,
                                         input logic [2:0] m);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*off +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (m)
      MASK_B:  return {{24{b[7]}}, b};
      MASK_BU: return {24'h0, b};
      MASK_H:  return {{16{h[15]}}, h};
      MASK_HU: return {16'h0, h};
      default: return w;
    endcase
  endfunction

  assign mem_rdata = ld_ext(mem[mem_addr[9:2]], mem_addr[1:0], mem_mask);

  always @(negedge clk) begin
    if (mem_wr_en) mem[mem_addr[9:2]] <= merge(mem[mem_addr[9:2]], mem_addr[1:0], mem_wdata, mem_mask);
  end

  // Drain scoreboard: expected writes queued when a store is accepted.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  mask;
  } wr_t;
  wr_t sb_q[$];

  always @(negedge clk) begin
    wr_t e;
    chk("port_exclusive", {31'b0, mem_wr_en & mem_rd_en}, 32'd0);
    if (mem_wr_en) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
      end else begin
        e = sb_q.pop_front();
        chk("drain_addr", mem_addr, e.addr);
        chk("drain_data", mem_wdata, e.data);
        chk("drain_mask", {29'b0, mem_mask}, {29'b0, e.mask});
      end
    end
    chk("outstanding_le_depth", {31'b0, sb_q.size() <= DEPTH}, 32'd1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_wr_en = 1'b0;
    cpu_rd_en = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    cpu_mask  = MASK_B;
  endtask

  // Called at posedge+1; returns at the posedge+1 after acceptance.
  task automatic do_op(input logic wr, input logic rd, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] m,
                       output int stalls, output logic [31:0] rdata);
    cpu_wr_en = wr;
    cpu_rd_en = rd;
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_mask  = m;
    stalls    = 0;
    rdata     = '0;
    #3;
    while (cpu_stall && stalls < 20) begin
      stalls++;
      @(posedge clk);
      #4;
    end
    if (cpu_stall) chk("op_timeout", 32'd1, 32'd0);
    else begin
      rdata = cpu_rdata;
      if (wr) sb_q.push_back('{a, d, m});
    end
    tick();
    idle_inputs();
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (!empty && n < 30) begin
      tick();
      n++;
    end
    chk(name, {31'b0, empty}, 32'd1);
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  mask;
    logic [31:0] exp_rd;
    int          exp_stall;
  } vec_t;

  localparam int NV = 15;
  vec_t vt [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          st;
    logic [31:0] rd;

    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0] = 32'hCAFEF00D;
    idle_inputs();
    reset = 1'b1;

    //               wr    rd    addr      data          mask     exp_rd        stall
    vt[0]  = '{1'b1, 1'b0, 32'h21, 32'h000000AA, MASK_B,  32'h0,         0};
    vt[1]  = '{1'b0, 1'b1, 32'h20, 32'h0,        MASK_W,  32'h0000AA00,  1};
    vt[2]  = '{1'b1, 1'b0, 32'h40, 32'h11111111, MASK_W,  32'h0,         0};
    vt[3]  = '{1'b1, 1'b0, 32'h42, 32'h00002222, MASK_H,  32'h0,         0};
    vt[4]  = '{1'b0, 1'b1, 32'h40, 32'h0,        MASK_W,  32'h22221111,  1};
    vt[5]  = '{1'b0, 1'b1, 32'h10, 32'h0,        MASK_W,  32'hDEADBEEF,  0};
    vt[6]  = '{1'b1, 1'b0, 32'h53, 32'h00000080, MASK_B,  32'h0,         0};
    vt[7]  = '{1'b0, 1'b1, 32'h53, 32'h0,        MASK_B,  32'hFFFFFF80,  1};
    vt[8]  = '{1'b0, 1'b1, 32'h53, 32'h0,        MASK_BU, 32'h00000080,  0};
    vt[9]  = '{1'b0, 1'b1, 32'h42, 32'h0,        MASK_H,  32'h00002222,  0};
    vt[10] = '{1'b1, 1'b0, 32'h62, 32'h00008001, MASK_H,  32'h0,         0};
    vt[11] = '{1'b0, 1'b1, 32'h62, 32'h0,        MASK_HU, 32'h00008001,  1};
    vt[12] = '{1'b0, 1'b1, 32'h62, 32'h0,        MASK_H,  32'hFFFF8001,  0};
    vt[13] = '{1'b0, 1'b1, 32'h60, 32'h0,        MASK_W,  32'h80010000,  0};
    vt[14] = '{1'b0, 1'b1, 32'h21, 32'h0,        MASK_BU, 32'h000000AA,  0};

    // Reset then idle.
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #3;
      chk("idle_empty", {31'b0, empty}, 32'd1);
      chk("idle_wr_en", {31'b0, mem_wr_en}, 32'd0);
      chk("idle_rd_en", {31'b0, mem_rd_en}, 32'd0);
      chk("idle_stall", {31'b0, cpu_stall}, 32'd0);
      chk("idle_rdata", cpu_rdata, 32'd0);
      tick();
    end

    // Single store, drained the cycle after it is pushed.
    cpu_wr_en = 1'b1;
    cpu_addr  = 32'h10;
    cpu_wdata = 32'hDEADBEEF;
    cpu_mask  = MASK_W;
    #3;
    chk("sw_stall", {31'b0, cpu_stall}, 32'd0);
    chk("sw_no_bypass", {31'b0, mem_wr_en}, 32'd0);
    sb_q.push_back('{32'h10, 32'hDEADBEEF, MASK_W});
    tick();
    idle_inputs();
    #3;
    chk("sw_drain_en", {31'b0, mem_wr_en}, 32'd1);
    chk("sw_drain_addr", mem_addr, 32'h10);
    chk("sw_not_empty", {31'b0, empty}, 32'd0);
    tick();
    #3;
    chk("sw_empty_after", {31'b0, empty}, 32'd1);
    chk("sw_mem", mem[4], 32'hDEADBEEF);
    tick();

    // Load/store vector table.
    for (int i = 0; i < NV; i++) begin
      do_op(vt[i].wr, vt[i].rd, vt[i].addr, vt[i].data, vt[i].mask, st, rd);
      if (vt[i].rd) chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
      chk($sformatf("vec%0d_stalls", i), st, vt[i].exp_stall);
    end
    wait_empty("table_drain");

    // Fill the buffer while loads own the port; 5th store waits for a load-free cycle.
    for (int k = 0; k < 4; k++) begin
      cpu_wr_en = 1'b1;
      cpu_rd_en = 1'b1;
      cpu_addr  = 32'h100 + 32'(4 * k);
      cpu_wdata = 32'hA0000000 + 32'(k);
      cpu_mask  = MASK_W;
      #3;
      chk("fill_stall", {31'b0, cpu_stall}, 32'd0);
      chk("fill_load_port", {30'b0, mem_rd_en, mem_wr_en}, 32'd2);
      sb_q.push_back('{cpu_addr, cpu_wdata, MASK_W});
      tick();
    end
    cpu_addr  = 32'h110;
    cpu_wdata = 32'hA0000004;
    for (int k = 0; k < 2; k++) begin
      #3;
      chk("full_stall", {31'b0, cpu_stall}, 32'd1);
      chk("full_no_drain", {31'b0, mem_wr_en}, 32'd0);
      tick();
    end
    cpu_rd_en = 1'b0;
    #3;
    chk("full_stall_drain", {31'b0, cpu_stall}, 32'd1);
    chk("full_drain_en", {31'b0, mem_wr_en}, 32'd1);
    chk("full_drain_addr", mem_addr, 32'h100);
    tick();
    #3;
    chk("full_accept", {31'b0, cpu_stall}, 32'd0);
    sb_q.push_back('{32'h110, 32'hA0000004, MASK_W});
    tick();
    idle_inputs();
    wait_empty("fill_drain");
    chk("fill_mem_first", mem[32'h100 >> 2], 32'hA0000000);
    chk("fill_mem_last", mem[32'h110 >> 2], 32'hA0000004);

    // Reset with three buffered stores: none may reach memory.
    for (int k = 0; k < 3; k++) begin
      cpu_wr_en = 1'b1;
      cpu_rd_en = 1'b1;
      cpu_addr  = 32'h200 + 32'(4 * k);
      cpu_wdata = 32'hBB000000 + 32'(k);
      cpu_mask  = MASK_W;
      tick();
    end
    idle_inputs();
    reset = 1'b1;
    #3;
    chk("rst_no_drain", {31'b0, mem_wr_en}, 32'd0);
    chk("rst_stall", {31'b0, cpu_stall}, 32'd0);
    tick();
    reset = 1'b0;
    #3;
    chk("rst_empty", {31'b0, empty}, 32'd1);
    for (int k = 0; k < 4; k++) tick();
    chk("rst_mem0", mem[32'h200 >> 2], 32'd0);
    chk("rst_mem1", mem[32'h204 >> 2], 32'd0);
    chk("rst_mem2", mem[32'h208 >> 2], 32'd0);

    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
